// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: branch/jump/jr/exception redirects with one MIPS delay slot plus a jr $31 return-address cross-check.
// Redirects land on the next edge; stall freezes every register including FSM, RAS and counter.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              dec_valid,
    input  logic [31:0]       instruction,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jump_register,
    input  logic              link,
    input  logic [ADDR_W-1:0] register_value,
    input  logic              exception,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              in_delay_slot,
    output logic [ADDR_W-1:0] epc,
    output logic              ras_empty,
    output logic [15:0]       ras_mismatch_count
);

    localparam int                PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]    RAS_FULL = RAS_DEPTH[PTR_W:0];
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(8);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_EXC  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] brOffset;
    logic [ADDR_W-1:0] brTgt;
    logic [ADDR_W-1:0] jTgt;
    logic [ADDR_W-1:0] jrTgt;

    logic [ADDR_W-1:0] fetchNext;
    logic [ADDR_W-1:0] epcNext;
    logic              slotNext;

    logic              decLive;
    logic              ctrlLive;
    logic              takeJump;
    logic              takeBranch;
    logic              rasPush;
    logic              rasPop;
    logic              rasMiss;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  rasPtr;
    logic [PTR_W:0]    rasCount;
    logic [ADDR_W-1:0] rasTop;

    logic              unusedBits;

    // Target arithmetic wraps modulo 2^ADDR_W.
    assign pc4       = dec_pc + PC_STEP;
    assign brOffset  = {{(ADDR_W-18){instruction[15]}}, instruction[15:0], 2'b00};
    assign brTgt     = pc4 + brOffset;
    assign jTgt      = {pc4[ADDR_W-1:28], instruction[25:0], 2'b00};
    assign jrTgt     = {register_value[ADDR_W-1:2], 2'b00};
    assign link_addr = dec_pc + LINK_OFS;

    assign unusedBits = ^{instruction[31:26], register_value[1:0]};

    // Decode is only meaningful in S_RUN; an exception flushes it, and a
    // control instruction sitting in a delay slot is treated as sequential.
    assign decLive    = (state == S_RUN) && dec_valid;
    assign ctrlLive   = decLive && !exception && !in_delay_slot;
    assign takeJump   = ctrlLive && jump;
    assign takeBranch = ctrlLive && !jump && branch && branch_taken;

    assign rasPush = takeJump && link;
    assign rasPop  = takeJump && jump_register && !link && (instruction[25:21] == 5'd31);

    assign ras_empty = (rasCount == '0);
    assign rasTop    = ras[rasPtr - 1'b1];
    assign rasMiss   = rasPop && !ras_empty && (rasTop != jrTgt);

    always_comb begin
        stateNext = S_RUN;
        fetchNext = fetch_pc + PC_STEP;
        epcNext   = epc;
        slotNext  = 1'b0;
        if (exception) begin
            stateNext = S_EXC;
            fetchNext = EXC_VECTOR;
            if (in_delay_slot) begin
                epcNext = dec_pc - PC_STEP;
            end else if (decLive) begin
                epcNext = dec_pc;
            end else begin
                epcNext = fetch_pc;
            end
        end else if (takeJump) begin
            fetchNext = jump_register ? jrTgt : jTgt;
            slotNext  = 1'b1;
        end else if (takeBranch) begin
            fetchNext = brTgt;
            slotNext  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_BOOT;
            fetch_pc           <= RESET_VECTOR;
            dec_pc             <= RESET_VECTOR;
            epc                <= '0;
            in_delay_slot      <= 1'b0;
            rasPtr             <= '0;
            rasCount           <= '0;
            ras_mismatch_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (!stall) begin
            state         <= stateNext;
            fetch_pc      <= fetchNext;
            dec_pc        <= fetch_pc;
            epc           <= epcNext;
            in_delay_slot <= slotNext;

            // Circular stack: a push onto a full stack silently drops the oldest entry.
            if (rasPush) begin
                ras[rasPtr] <= link_addr;
                rasPtr      <= rasPtr + 1'b1;
                if (rasCount != RAS_FULL) begin
                    rasCount <= rasCount + 1'b1;
                end
            end else if (rasPop && !ras_empty) begin
                rasPtr   <= rasPtr - 1'b1;
                rasCount <= rasCount - 1'b1;
            end

            if (rasMiss && (ras_mismatch_count != 16'hFFFF)) begin
                ras_mismatch_count <= ras_mismatch_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the combinational next-instruction calculator.
- Owns the fetch PC register and resolves branch, jump, jump-register and exception redirects.
- Honours the MIPS single branch-delay slot.
- Keeps a small return-address stack (RAS) that cross-checks jr $31 targets, for debug and later prediction.
- Sits between the decode stage and instruction memory.

Parameters:
ADDR_W, 32, PC/address width (≥ 30, must be a multiple of 2 ≥ 30).
RESET_VECTOR, 32'h0040_0000, PC loaded on reset.
EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
RAS_DEPTH, 4, return-address stack entries (power of 2, ≥ 2).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and all state this cycle
dec_valid  in  1  decode-stage instruction is valid
instruction  in  32  decode-stage instruction bits
branch  in  1  decode instr is a conditional branch
branch_taken  in  1  branch condition true (ignored unless branch)
jump  in  1  decode instr is j/jal/jr/jalr
jump_register  in  1  jump takes target from register_value
link  in  1  instr is jal/jalr (pushes RAS)
register_value  in  ADDR_W  rs value for jr/jalr
exception  in  1  take exception this cycle
fetch_pc  out  ADDR_W  address fetched this cycle
dec_pc  out  ADDR_W  address of the instruction in decode
link_addr  out  ADDR_W  dec_pc+8
in_delay_slot  out  1  instruction in decode is a delay slot
epc  out  ADDR_W  saved exception PC
ras_empty  out  1  RAS holds no entries
ras_mismatch_count  out  16  jr $31 targets that differed from the RAS top

Behaviour:
- Reset (rst=1 at an edge, overrides stall/exception):
  - fetch_pc=RESET_VECTOR, dec_pc=RESET_VECTOR, epc=0, in_delay_slot=0.
  - RAS pointer=0, ras_empty=1, ras_mismatch_count=0.
  - State=S_BOOT.
- States:
  - S_BOOT: exactly one cycle after reset; dec_valid ignored; next state S_RUN; fetch_pc advances by 4.
  - S_RUN: normal operation.
  - S_EXC: one cycle after an exception; decode input ignored (flushed); returns to S_RUN.
- stall=1: every register holds, including state, RAS and counter. Outputs stay stable.
- Normal advance, when not stalled:
  - dec_pc <= fetch_pc.
  - fetch_pc <= next (priority below).
  - in_delay_slot <= redirect_taken_this_cycle.
- Target arithmetic, modulo 2^ADDR_W (wraps silently):
  - pc4 = dec_pc+4.
  - br_tgt = pc4 + (sign-extended imm[15:0] << 2).
  - j_tgt = {pc4[ADDR_W-1:28], instruction[25:0], 2'b00}.
  - jr_tgt = register_value with bits [1:0] forced to 0.
- Next-PC priority:
  1. exception → EXC_VECTOR.
     - epc <= dec_pc if dec_valid else fetch_pc.
     - If in_delay_slot=1, epc <= dec_pc-4 (the branch).
     - State → S_EXC; no delay slot executes.
  2. dec_valid & jump → jr_tgt if jump_register else j_tgt.
  3. dec_valid & branch & branch_taken → br_tgt.
  4. Otherwise fetch_pc+4.
- Delay slot: a redirect in cases 2–3 lets the already-fetched fetch_pc (= dec_pc+4) proceed as the delay slot.
- Branch/jump inside a delay slot (in_delay_slot=1 and jump|branch): ignored as a control transfer; PC advances sequentially.
- RAS:
  - Push: dec_valid & jump & link writes link_addr.
  - Pop: dec_valid & jump & jump_register & !link & instruction[25:21]==31 pops the top.
  - On pop with ras_empty=0 and top ≠ jr_tgt: ras_mismatch_count increments, saturating at 16'hFFFF.
  - Pop when empty: no-op, no count.
  - Push when full: oldest entry overwritten (circular); ras_empty stays 0.
  - Push and pop never occur together; jalr $31 is treated as push only.
- Exception flush: RAS and counter are not affected by the flushed decode instruction.

Test Plan:
1. Reset hold 3 cycles, release → fetch_pc 0x00400000, 0x00400004, 0x00400008 on successive cycles; in_delay_slot=0; ras_empty=1.
2. beq at dec_pc 0x00400010, imm=0xFFFC, taken → next fetch 0x00400014 (delay slot, in_delay_slot=1 when in decode), then 0x00400004.
3. jal at 0x00400020, index 0x0100040 → fetch 0x00400024 then 0x00400100; link_addr=0x00400028; RAS pushed. Then jr $31 with register_value 0x00400028 → counter stays 0. Repeat with 0x00400030 → counter=1.
4. Exception while a branch's delay slot sits in decode (dec_pc=0x00400044, in_delay_slot=1) → fetch_pc=0x80000180, epc=0x00400040; the next decode is flushed.
5. stall=1 for 4 cycles during a taken branch → all outputs frozen; the redirect completes on the first unstalled edge.
6. Push 5 jal with RAS_DEPTH=4, then 5 jr $31 → first 4 pops compare against the last 4 links; 5th pop sees an empty RAS, is a no-op, and does not count.
